data_memory_ls: RTL and testbench

DATA_MEMORY_LS -- requirements
Module: data_memory_ls

---
 rtl/data_memory_ls.sv | 130 +++++++++++++
 tb/tb_data_memory_ls.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ls.sv
// Byte-addressable RV32 load/store data memory with a one-deep response register.
// Requests are checked for funct3 legality, alignment and range; rejects are counted.
module data_memory_ls #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Zero at power-up; reset deliberately leaves contents alone.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          accept;
    logic          illegal;
    logic          misaligned;
    logic          out_of_range;
    logic          err;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign req_ready    = !rst && (!rsp_valid || rsp_ready);
    assign accept       = req_valid && req_ready;
    assign idx          = req_addr[AW+1:2];
    assign lane         = req_addr[1:0];
    assign rd_word      = mem[idx];
    assign out_of_range = (req_addr[31:AW+2] != '0);
    assign err          = illegal || misaligned || out_of_range;

    // Size decode: legality, alignment, store lane enables and lane-replicated write data.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        wword      = req_wdata;
        case (req_funct3)
            F3_B: begin
                be    = 4'b0001 << lane;
                wword = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                misaligned = lane[0];
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wword      = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                misaligned = (lane != 2'b00);
                be         = 4'b1111;
            end
            F3_BU: illegal = req_we;
            F3_HU: begin
                illegal    = req_we;
                misaligned = lane[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = rd_word;
            F3_BU:   ld_data = {24'h000000, ld_byte};
            F3_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || req_we) ? '0 : ld_data;
                if (err && err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ls.sv
// Scoreboard bench for data_memory_ls: byte-array reference model, directed cases, random traffic.
module tb_data_memory_ls;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned ECW   = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [2:0]     req_funct3;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [ECW-1:0] err_count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          rdy_mode    = 0;
    int unsigned ecount      = 0;
    logic [7:0]  mem_b [DEPTH*4];
    rsp_t        expq [$];

    data_memory_ls #(
        .DEPTH_WORDS(DEPTH),
        .ERR_CNT_W  (ECW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, results computed from size/sign rules.
    function automatic rsp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        rsp_t        r;
        int unsigned n;
        logic [31:0] v;
        bit          bad;
        n   = 1 << f3[1:0];
        bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (f3[2] && we))
           || (f3[1:0] == 2'd1 && addr[0])
           || (f3 == 3'd2 && addr[1:0] != 2'd0)
           || ((addr >> 2) >= DEPTH);
        r.rdata = '0;
        r.err   = bad;
        if (bad) begin
            if (ecount < (1 << ECW) - 1) ecount++;
        end else if (we) begin
            for (int i = 0; i < int'(n); i++) mem_b[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(n); i++) v |= 32'(mem_b[int'(addr) + i]) << (8 * i);
            if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
            r.rdata = v;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int waited = 0;
        bit acc    = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        while (!acc && waited < 100) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            else waited++;
            if (!acc) step();
        end
        if (acc) begin
            expq.push_back(model(we, f3, addr, wd));
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready 0 for %0d cycles, required 1", waited);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", expq.size());
            expq.delete();
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = expq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom % 3) != 0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        logic [2:0]  f3_tab   [6] = '{3'd2, 3'd1, 3'd5, 3'd0, 3'd4, 3'd0};
        logic [31:0] addr_tab [6] = '{32'h10, 32'h12, 32'h10, 32'h12, 32'h11, 32'h13};
        logic [31:0] a;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        foreach (mem_b[i]) mem_b[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        step();
        rst = 1'b0;

        // Store then load, one-cycle latency on both.
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("store_latency_valid", 32'(rsp_valid), 32'd1);
        step();
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("load_latency_valid", 32'(rsp_valid), 32'd1);
        step();

        // Byte store with signed/unsigned byte loads.
        issue(1'b1, 3'b000, 32'h11, 32'h80);
        issue(1'b0, 3'b000, 32'h11, 32'h0);
        issue(1'b0, 3'b100, 32'h11, 32'h0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);

        // Rejects: misaligned half, misaligned store, out of range, illegal funct3.
        issue(1'b0, 3'b001, 32'h13, 32'h0);
        issue(1'b1, 3'b010, 32'h02, 32'h1234_5678);
        issue(1'b0, 3'b010, DEPTH * 4, 32'h0);
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        drain();
        chk("err_count_after_rejects", 32'(err_count), ecount);
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        drain();

        // Stalled response stays put and blocks new requests.
        rdy_mode = 1;
        step();
        issue(1'b0, 3'b101, 32'h12, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_rsp_rdata", rsp_rdata, expq[0].rdata);
            chk("hold_rsp_err", 32'(rsp_err), 32'(expq[0].err));
        end
        rdy_mode = 0;
        drain();

        // Back-to-back loads: one acceptance per cycle, response register never empties.
        step();
        start = cyc;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3_tab[i], addr_tab[i], 32'h0);
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        chk("b2b_cycles", 32'(cyc - start), 32'd6);
        drain();

        // Reset discards a pending response but keeps memory.
        rdy_mode = 1;
        step();
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("pending_before_rst", 32'(rsp_valid), 32'd1);
        step();
        rst = 1'b1;
        expq.delete();
        ecount = 0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_err_count", 32'(err_count), 32'd0);
        step();
        rdy_mode = 0;
        step();
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        drain();

        // Random traffic with random consumer back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) begin
                step();
            end else begin
                if ($urandom % 10 == 0) a = $urandom;
                else a = $urandom_range(0, DEPTH * 4 + 15);
                if ($urandom % 2 == 0) a[1:0] = 2'b00;
                issue(1'($urandom), 3'($urandom), a, $urandom);
            end
        end
        rdy_mode = 0;
        drain();
        chk("err_count_random", 32'(err_count), ecount);

        for (int w = 0; w < int'(DEPTH); w++) issue(1'b0, 3'b010, 32'(w * 4), 32'h0);
        drain();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
